// File: rtl/hamming_secded_pipe.sv
// Two-stage SECDED Hamming pipeline: stage 1 encodes the input word and
// applies an error mask, stage 2 decodes, corrects single-bit errors and
// classifies the beat. Saturating counters track corrected and
// uncorrectable beats as they leave the pipeline.
module hamming_secded_pipe #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16,
  // Smallest P with 2^P >= DATA_W + P + 1, written out for the legal range.
  localparam int P  = (DATA_W <= 4)  ? 3 :
                      (DATA_W <= 11) ? 4 :
                      (DATA_W <= 26) ? 5 :
                      (DATA_W <= 57) ? 6 : 7,
  localparam int CW = DATA_W + P + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CW-1:0]     i_noise,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [P-1:0]      o_syndrome,
  output logic              o_1bit_error,
  output logic              o_2bit_error,
  output logic              o_parity_error,
  input  logic              i_clr_cnt,
  output logic [CNT_W-1:0]  o_cnt_1bit,
  output logic [CNT_W-1:0]  o_cnt_2bit
);

  // Codeword positions 1, 2, 4, ... hold Hamming parity bits.
  function automatic bit is_pow2(input int i);
    return (i & (i - 1)) == 0;
  endfunction

  // Codeword position of data bit j: the j-th non-power-of-two index >= 3.
  function automatic int data_pos(input int j);
    int n;
    int res;
    n   = 0;
    res = 0;
    for (int i = 3; i < CW; i++) begin
      if (!is_pow2(i)) begin
        if (n == j) res = i;
        n++;
      end
    end
    return res;
  endfunction

  // Positions covered by parity bit k: every index with bit k set.
  function automatic logic [CW-1:0] cover_mask(input int k);
    logic [CW-1:0] m;
    m = '0;
    for (int i = 1; i < CW; i++) m[i] = ((i >> k) & 1) != 0;
    return m;
  endfunction

  // Parity bits are computed on the data-only vector; no parity position
  // falls inside another parity bit's coverage, so the order is free.
  function automatic logic [CW-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CW-1:0] c;
    c = '0;
    for (int j = 0; j < DATA_W; j++) c[data_pos(j)] = d[j];
    for (int k = 0; k < P; k++) c[1 << k] = ^(c & cover_mask(k));
    c[0] = ^c[CW-1:1];
    return c;
  endfunction

  logic              rdy_en;
  logic              s1_full;
  logic [CW-1:0]     s1_cw;
  logic              s2_full;
  logic              s1_load;
  logic              s2_load;
  logic              out_hs;

  logic [P-1:0]      dec_syn;
  logic              dec_par;
  logic [CW-1:0]     dec_fixed;
  logic [DATA_W-1:0] dec_data;
  logic              dec_1bit;
  logic              dec_2bit;
  logic              dec_perr;

  // rdy_en keeps o_ready low through reset and rises on the first edge after it.
  assign s2_load = s1_full && (!s2_full || i_ready);
  assign o_ready = rdy_en && (!s1_full || s2_load);
  assign s1_load = i_valid && o_ready;
  assign o_valid = s2_full;
  assign out_hs  = s2_full && i_ready;

  // Syndrome, overall parity, correction and beat classification.
  always_comb begin
    dec_syn   = '0;
    dec_fixed = s1_cw;
    dec_1bit  = 1'b0;
    dec_2bit  = 1'b0;
    dec_perr  = 1'b0;
    dec_data  = '0;
    for (int k = 0; k < P; k++) dec_syn[k] = ^(s1_cw & cover_mask(k));
    dec_par = ^s1_cw;
    if (dec_syn == '0) begin
      dec_perr = dec_par;
    end else if (dec_par && (int'(dec_syn) < CW)) begin
      dec_1bit = 1'b1;
      for (int i = 1; i < CW; i++) begin
        if (int'(dec_syn) == i) dec_fixed[i] = ~dec_fixed[i];
      end
    end else begin
      // Even parity with a nonzero syndrome, or a syndrome pointing past the
      // codeword: more than one bit is wrong, so leave the word untouched.
      dec_2bit = 1'b1;
    end
    for (int j = 0; j < DATA_W; j++) dec_data[j] = dec_fixed[data_pos(j)];
  end

  // Ready enable: cleared by reset, set on the first clock after release.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) rdy_en <= 1'b0;
    else       rdy_en <= 1'b1;
  end

  // Stage 1: capture the noisy codeword on an input handshake.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_full <= 1'b0;
      s1_cw   <= '0;
    end else if (s1_load) begin
      s1_full <= 1'b1;
      s1_cw   <= encode(i_data) ^ i_noise;
    end else if (s2_load) begin
      s1_full <= 1'b0;
    end
  end

  // Stage 2: register decoded results; hold them while downstream stalls.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s2_full        <= 1'b0;
      o_data         <= '0;
      o_syndrome     <= '0;
      o_1bit_error   <= 1'b0;
      o_2bit_error   <= 1'b0;
      o_parity_error <= 1'b0;
    end else if (s2_load) begin
      s2_full        <= 1'b1;
      o_data         <= dec_data;
      o_syndrome     <= dec_syn;
      o_1bit_error   <= dec_1bit;
      o_2bit_error   <= dec_2bit;
      o_parity_error <= dec_perr;
    end else if (i_ready) begin
      s2_full <= 1'b0;
    end
  end

  // Saturating error counters, bumped on output handshakes; clear wins.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_cnt_1bit <= '0;
      o_cnt_2bit <= '0;
    end else if (i_clr_cnt) begin
      o_cnt_1bit <= '0;
      o_cnt_2bit <= '0;
    end else if (out_hs) begin
      if ((o_1bit_error || o_parity_error) && (o_cnt_1bit != '1))
        o_cnt_1bit <= o_cnt_1bit + CNT_W'(1);
      if (o_2bit_error && (o_cnt_2bit != '1))
        o_cnt_2bit <= o_cnt_2bit + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hamming_secded_pipe.sv
// Bench for hamming_secded_pipe (DATA_W=8): directed vector table, single-bit
// sweep under random backpressure, stall ordering, counter saturation/clear
// and mid-stream reset. A second instance with CNT_W=2 shares all inputs.
module tb_hamming_secded_pipe;

  typedef struct {
    logic [7:0]  din;
    logic [12:0] noise;
    logic [7:0]  dout;
    logic [3:0]  synd;
    logic        f1;
    logic        f2;
    logic        fp;
    logic        chk;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b1;
  logic [7:0]  i_data = '0;
  logic [12:0] i_noise = '0;
  logic        i_clr_cnt = 1'b0;

  logic        o_ready, o_valid, o_1bit_error, o_2bit_error, o_parity_error;
  logic [7:0]  o_data;
  logic [3:0]  o_syndrome;
  logic [15:0] o_cnt_1bit, o_cnt_2bit;

  logic        c_ready, c_valid, c_f1, c_f2, c_fp;
  logic [7:0]  c_data;
  logic [3:0]  c_synd;
  logic [1:0]  c_cnt1, c_cnt2;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t sb[$];
  vec_t vecs[12];

  logic [15:0] exp1 = '0, exp2 = '0;
  logic [1:0]  expc1 = '0, expc2 = '0;
  logic        hs_pend = 1'b0, inc1 = 1'b0, inc2 = 1'b0;
  logic        sweep_done = 1'b0;

  always #5 clk = ~clk;

  hamming_secded_pipe #(.DATA_W(8), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_noise(i_noise), .o_valid(o_valid), .i_ready(i_ready),
    .o_data(o_data), .o_syndrome(o_syndrome), .o_1bit_error(o_1bit_error),
    .o_2bit_error(o_2bit_error), .o_parity_error(o_parity_error),
    .i_clr_cnt(i_clr_cnt), .o_cnt_1bit(o_cnt_1bit), .o_cnt_2bit(o_cnt_2bit)
  );

  hamming_secded_pipe #(.DATA_W(8), .CNT_W(2)) dut_c (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(c_ready),
    .i_data(i_data), .i_noise(i_noise), .o_valid(c_valid), .i_ready(i_ready),
    .o_data(c_data), .o_syndrome(c_synd), .o_1bit_error(c_f1),
    .o_2bit_error(c_f2), .o_parity_error(c_fp),
    .i_clr_cnt(i_clr_cnt), .o_cnt_1bit(c_cnt1), .o_cnt_2bit(c_cnt2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one beat (called just after a rising edge), wait for the handshake.
  task automatic send(input logic [7:0] d, input logic [12:0] n, input vec_t e);
    int t;
    i_valid = 1'b1;
    i_data  = d;
    i_noise = n;
    for (t = 0; t < 200; t++) begin
      @(negedge clk);
      if (o_ready) break;
    end
    if (t >= 200) check("send_timeout", 1, 0);
    sb.push_back(e);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 400 && sb.size() != 0; t++) @(negedge clk);
    check("drain", sb.size(), 0);
  endtask

  function automatic vec_t mk(input logic [7:0] d, input logic [12:0] n, input logic [7:0] o,
                              input logic [3:0] s, input logic f1, input logic f2,
                              input logic fp, input logic chk);
    vec_t v;
    v.din = d; v.noise = n; v.dout = o; v.synd = s;
    v.f1 = f1; v.f2 = f2; v.fp = fp; v.chk = chk;
    return v;
  endfunction

  // Output monitor: pop and compare on each handshake, check counters.
  always @(negedge clk) begin
    vec_t e;
    if (rst) begin
      hs_pend <= 1'b0;
    end else begin
      check("cnt_1bit", o_cnt_1bit, exp1);
      check("cnt_2bit", o_cnt_2bit, exp2);
      check("c_cnt_1bit", c_cnt1, expc1);
      check("c_cnt_2bit", c_cnt2, expc2);
      hs_pend <= 1'b0;
      if (o_valid && i_ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got data %0h expected no beat", o_data);
        end else begin
          e = sb.pop_front();
          if (e.chk) begin
            check("data", o_data, e.dout);
            check("syndrome", o_syndrome, e.synd);
            check("flags", {o_1bit_error, o_2bit_error, o_parity_error}, {e.f1, e.f2, e.fp});
            check("c_data", c_data, e.dout);
            check("c_syndrome", c_synd, e.synd);
            check("c_flags", {c_f1, c_f2, c_fp}, {e.f1, e.f2, e.fp});
          end
          hs_pend <= 1'b1;
          inc1    <= e.f1 | e.fp;
          inc2    <= e.f2;
        end
      end
    end
  end

  // Counter reference model.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp1 <= '0; exp2 <= '0; expc1 <= '0; expc2 <= '0;
    end else if (i_clr_cnt) begin
      exp1 <= '0; exp2 <= '0; expc1 <= '0; expc2 <= '0;
    end else if (hs_pend) begin
      if (inc1 && exp1 != 16'hFFFF) exp1 <= exp1 + 16'd1;
      if (inc2 && exp2 != 16'hFFFF) exp2 <= exp2 + 16'd1;
      if (inc1 && expc1 != 2'd3) expc1 <= expc1 + 2'd1;
      if (inc2 && expc2 != 2'd3) expc2 <= expc2 + 2'd1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //        din     noise     dout    syn  f1 f2 fp chk
    vecs[0]  = mk(8'hA5, 13'h0000, 8'hA5, 4'd0,  0, 0, 0, 1);
    vecs[1]  = mk(8'hA5, 13'h0008, 8'hA5, 4'd3,  1, 0, 0, 1);
    vecs[2]  = mk(8'hA5, 13'h0001, 8'hA5, 4'd0,  0, 0, 1, 1);
    vecs[3]  = mk(8'hA5, 13'h0006, 8'hA5, 4'd3,  0, 1, 0, 1);
    vecs[4]  = mk(8'hA5, 13'h0007, 8'h00, 4'd3,  1, 0, 0, 0);
    vecs[5]  = mk(8'h3C, 13'h1000, 8'h3C, 4'd12, 1, 0, 0, 1);
    vecs[6]  = mk(8'h3C, 13'h0030, 8'h3E, 4'd1,  0, 1, 0, 1);
    vecs[7]  = mk(8'hFF, 13'h0A00, 8'hAF, 4'd2,  0, 1, 0, 1);
    vecs[8]  = mk(8'h5A, 13'h0112, 8'h5A, 4'd13, 0, 1, 0, 1);
    vecs[9]  = mk(8'h00, 13'h0228, 8'h13, 4'd15, 0, 1, 0, 1);
    vecs[10] = mk(8'h81, 13'h0002, 8'h81, 4'd1,  1, 0, 0, 1);
    vecs[11] = mk(8'h00, 13'h0000, 8'h00, 4'd0,  0, 0, 0, 1);

    // Reset state.
    #12;
    check("rst_valid", o_valid, 0);
    check("rst_ready", o_ready, 0);
    check("rst_data", o_data, 0);
    check("rst_syndrome", o_syndrome, 0);
    check("rst_flags", {o_1bit_error, o_2bit_error, o_parity_error}, 3'b000);
    check("rst_cnt", {o_cnt_1bit, o_cnt_2bit}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ready_before_first_edge", o_ready, 0);
    @(negedge clk);
    check("ready_after_release", o_ready, 1);

    // Latency of a lone clean beat.
    step();
    send(8'hA5, 13'h0000, vecs[0]);
    @(negedge clk);
    check("latency_valid_c1", o_valid, 0);
    @(negedge clk);
    check("latency_valid_c2", o_valid, 1);
    check("latency_data", o_data, 8'hA5);
    step();

    // Directed vector table, back-to-back.
    for (int i = 0; i < 12; i++) send(vecs[i].din, vecs[i].noise, vecs[i]);
    drain();
    step();
    @(negedge clk);
    check("table_cnt_1bit", o_cnt_1bit, 16'd5);
    check("table_cnt_2bit", o_cnt_2bit, 16'd5);
    check("sat_cnt_1bit", c_cnt1, 2'd3);
    check("sat_cnt_2bit", c_cnt2, 2'd3);

    // Counter clear.
    step();
    i_clr_cnt = 1'b1;
    step();
    i_clr_cnt = 1'b0;
    @(negedge clk);
    check("clr_cnt_1bit", o_cnt_1bit, 0);
    check("clr_cnt_2bit", o_cnt_2bit, 0);
    check("clr_c_cnt_1bit", c_cnt1, 0);

    // Clear coinciding with a corrected beat leaving the pipe.
    step();
    i_ready = 1'b0;
    send(8'hA5, 13'h0008, vecs[1]);
    for (int t = 0; t < 20 && !o_valid; t++) @(negedge clk);
    check("clr_beat_valid", o_valid, 1);
    step();
    i_ready   = 1'b1;
    i_clr_cnt = 1'b1;
    step();
    i_clr_cnt = 1'b0;
    @(negedge clk);
    check("clr_prio_cnt_1bit", o_cnt_1bit, 0);
    check("clr_prio_c_cnt_1bit", c_cnt1, 0);
    check("clr_prio_empty", sb.size(), 0);

    // Single-bit sweep over all data values with random backpressure.
    step();
    fork
      begin
        for (int k = 1; k < 13; k++) begin
          for (int d = 0; d < 256; d++) begin
            logic [12:0] nz;
            nz = 13'd1 << k;
            send(8'(d), nz, mk(8'(d), nz, 8'(d), 4'(k), 1, 0, 0, 1));
          end
        end
        sweep_done = 1'b1;
      end
      begin
        while (!sweep_done) begin
          step();
          i_ready = ($urandom_range(0, 3) != 0);
        end
        i_ready = 1'b1;
      end
    join
    drain();

    // Stall: two beats fill the pipe, then order is kept after release.
    step();
    i_ready = 1'b0;
    send(8'h01, 13'h0, mk(8'h01, 13'h0, 8'h01, 4'd0, 0, 0, 0, 1));
    send(8'h02, 13'h0, mk(8'h02, 13'h0, 8'h02, 4'd0, 0, 0, 0, 1));
    @(negedge clk);
    check("stall_ready", o_ready, 0);
    check("stall_data", o_data, 8'h01);
    step();
    @(negedge clk);
    check("stall_hold_valid", o_valid, 1);
    check("stall_hold_data", o_data, 8'h01);
    check("stall_hold_ready", o_ready, 0);
    step();
    i_ready = 1'b1;
    send(8'h03, 13'h0, mk(8'h03, 13'h0, 8'h03, 4'd0, 0, 0, 0, 1));
    send(8'h04, 13'h0, mk(8'h04, 13'h0, 8'h04, 4'd0, 0, 0, 0, 1));
    drain();

    // Reset with two beats in flight.
    step();
    i_ready = 1'b0;
    send(8'h11, 13'h0000, mk(8'h11, 13'h0, 8'h11, 4'd0, 0, 0, 0, 1));
    send(8'h22, 13'h0008, mk(8'h22, 13'h8, 8'h22, 4'd3, 1, 0, 0, 1));
    check("pre_rst_cnt_nonzero", (o_cnt_1bit != 0), 1);
    #3 rst = 1'b1;
    sb.delete();
    #1;
    check("midrst_valid", o_valid, 0);
    check("midrst_ready", o_ready, 0);
    check("midrst_data", o_data, 0);
    check("midrst_cnt_1bit", o_cnt_1bit, 0);
    check("midrst_c_cnt_1bit", c_cnt1, 0);
    i_ready = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready0", o_ready, 0);
    @(negedge clk);
    check("post_rst_ready1", o_ready, 1);
    check("post_rst_valid", o_valid, 0);
    step();
    send(8'h77, 13'h0000, mk(8'h77, 13'h0, 8'h77, 4'd0, 0, 0, 0, 1));
    @(negedge clk);
    check("post_rst_lat_c1", o_valid, 0);
    @(negedge clk);
    check("post_rst_lat_c2", o_valid, 1);
    check("post_rst_data", o_data, 8'h77);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
